pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its surroundings.
// The master drives the control and decode inputs; the sequencer is the slave.
`timescale 1ns/1ps
interface pc_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              run;
    logic              halt_req;
    logic              mem_ack;
    logic              jump;
    logic              cond_ok;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              pc_enable;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_preload;
    logic              mem_req;
    logic              halted;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output run, halt_req, mem_ack, jump, cond_ok, call, ret, target, pc,
        input  pc_enable, pc_load, pc_preload, mem_req, halted,
               stack_overflow, stack_underflow
    );

    modport slave (
        input  run, halt_req, mem_ack, jump, cond_ok, call, ret, target, pc,
        output pc_enable, pc_load, pc_preload, mem_req, halted,
               stack_overflow, stack_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC/HALT control with a
// return-address stack. PC strobes are decided combinationally during the
// single EXEC cycle; everything else comes straight from registers.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic              stack_empty;
    logic              stack_full;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic [ADDR_W-1:0] return_addr;
    logic              do_ret, ret_err, do_call, call_err, do_jump, do_seq;
    logic [ADDR_W-1:0] preload_mux;

    assign stack_empty = (count_reg == '0);
    assign stack_full  = (count_reg == CNT_W'(STACK_DEPTH));
    assign top_idx     = IDX_W'(count_reg - CNT_W'(1));
    assign push_idx    = IDX_W'(count_reg);
    // Wraps naturally: the last address pushes zero.
    assign return_addr = bus.pc + ADDR_W'(1);

    // EXEC decode with priority ret > call > jump > sequential; reset masks it.
    always_comb begin
        do_ret   = 1'b0;
        ret_err  = 1'b0;
        do_call  = 1'b0;
        call_err = 1'b0;
        do_jump  = 1'b0;
        do_seq   = 1'b0;
        if (state_reg == EXEC && !reset) begin
            if (bus.ret) begin
                if (stack_empty) ret_err = 1'b1;
                else             do_ret  = 1'b1;
            end else if (bus.call) begin
                if (stack_full) call_err = 1'b1;
                else            do_call  = 1'b1;
            end else if (bus.jump && bus.cond_ok) begin
                do_jump = 1'b1;
            end else begin
                do_seq = 1'b1;
            end
        end
    end

    // Preload value is forced to zero whenever no load is issued.
    always_comb begin
        preload_mux = '0;
        if (do_ret)                 preload_mux = stack_mem[top_idx];
        else if (do_call || do_jump) preload_mux = bus.target;
    end

    assign bus.pc_load         = do_ret | do_call | do_jump;
    assign bus.pc_enable       = do_seq;
    assign bus.pc_preload      = preload_mux;
    assign bus.mem_req         = (state_reg == FETCH);
    assign bus.halted          = (state_reg == HALT);
    assign bus.stack_overflow  = overflow_reg;
    assign bus.stack_underflow = underflow_reg;

    // Stack storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_call) stack_mem[push_idx] <= return_addr;
    end

    // Sequencer state, stack occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.run) state_reg <= FETCH;
                end
                FETCH: begin
                    if (bus.mem_ack) state_reg <= EXEC;
                end
                EXEC: begin
                    if (ret_err) begin
                        underflow_reg <= 1'b1;
                        state_reg     <= HALT;
                    end else if (call_err) begin
                        overflow_reg <= 1'b1;
                        state_reg    <= HALT;
                    end else begin
                        if (do_ret)  count_reg <= count_reg - CNT_W'(1);
                        if (do_call) count_reg <= count_reg + CNT_W'(1);
                        state_reg <= bus.halt_req ? HALT : FETCH;
                    end
                end
                HALT: begin
                    if (bus.run && !overflow_reg && !underflow_reg) state_reg <= FETCH;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of per-cycle vectors, directed overflow
// and stall/reset sequences, then random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(12)) bus ();

    pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst, run, hreq, ack, jmp, cok, cal, rt;
        logic [11:0] tgt, pcv;
        logic        en, ld;
        logic [11:0] pre;
        logic        mreq, hlt, ovf, udf;
    } vec_t;

    function automatic vec_t mk(logic rst, logic run, logic hreq, logic ack,
                                logic jmp, logic cok, logic cal, logic rt,
                                logic [11:0] tgt, logic [11:0] pcv,
                                logic en, logic ld, logic [11:0] pre,
                                logic mreq, logic hlt, logic ovf, logic udf);
        vec_t v;
        v.rst = rst; v.run = run; v.hreq = hreq; v.ack = ack;
        v.jmp = jmp; v.cok = cok; v.cal = cal; v.rt = rt;
        v.tgt = tgt; v.pcv = pcv;
        v.en = en; v.ld = ld; v.pre = pre;
        v.mreq = mreq; v.hlt = hlt; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic drive(logic rst, logic run, logic hreq, logic ack, logic jmp,
                         logic cok, logic cal, logic rt, logic [11:0] tgt, logic [11:0] pcv);
        reset = rst; bus.run = run; bus.halt_req = hreq; bus.mem_ack = ack;
        bus.jump = jmp; bus.cond_ok = cok; bus.call = cal; bus.ret = rt;
        bus.target = tgt; bus.pc = pcv;
    endtask

    task automatic check(string nm, logic en, logic ld, logic [11:0] pre,
                         logic mreq, logic hlt, logic ovf, logic udf);
        logic [17:0] got, want;
        got  = {bus.pc_enable, bus.pc_load, bus.pc_preload, bus.mem_req,
                bus.halted, bus.stack_overflow, bus.stack_underflow};
        want = {en, ld, pre, mreq, hlt, ovf, udf};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got en=%b ld=%b pre=%h mreq=%b halted=%b ovf=%b udf=%b, expected en=%b ld=%b pre=%h mreq=%b halted=%b ovf=%b udf=%b",
                     nm, got[17], got[16], got[15:4], got[3], got[2], got[1], got[0],
                     en, ld, pre, mreq, hlt, ovf, udf);
        end
    endtask

    // One cycle: drive, sample on the falling edge, then pass the rising edge.
    task automatic cyc(vec_t v, string nm);
        drive(v.rst, v.run, v.hreq, v.ack, v.jmp, v.cok, v.cal, v.rt, v.tgt, v.pcv);
        @(negedge clk);
        check(nm, v.en, v.ld, v.pre, v.mreq, v.hlt, v.ovf, v.udf);
        $display("cycle %s rst=%b run=%b ack=%b j=%b c=%b call=%b ret=%b tgt=%h pc=%h",
                 nm, v.rst, v.run, v.ack, v.jmp, v.cok, v.cal, v.rt, v.tgt, v.pcv);
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    vec_t vecs[29];

    // Reference model state
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
    int          m_mode;
    logic [11:0] m_stack[$];
    bit          m_ovf, m_udf;

    initial begin
        //           rst run hr ack j  ok cl rt tgt     pc       en ld pre     mq hl ov ud
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 12'h000, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h010, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 12'h200, 12'h010, 0, 1, 12'h200, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h200, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 12'h055, 12'h200, 1, 0, 12'h000, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h201, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 0, 0, 12'h0AB, 12'h201, 0, 1, 12'h0AB, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h0AB, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 1, 1, 12'h123, 12'h0AB, 0, 1, 12'h011, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 1, 1, 1, 0, 0, 12'h000, 12'h011, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h011, 0, 0, 12'h000, 0, 0, 0, 0);
        vecs[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h011, 0, 0, 12'h000, 0, 1, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h011, 0, 0, 12'h000, 0, 1, 0, 1);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 1, 0, 1);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 12'h000, 0, 1, 0, 0);
        vecs[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 12'h000, 0, 1, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 1, 0, 12'h300, 12'hFFF, 0, 1, 12'h300, 0, 0, 0, 0);
        vecs[27] = mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h300, 0, 0, 12'h000, 1, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 1, 12'h000, 12'h300, 0, 1, 12'h000, 0, 0, 0, 0);

        reset_dut();
        for (int i = 0; i < 29; i++) cyc(vecs[i], $sformatf("vec%0d", i));

        // Overflow: four calls fill the stack, the fifth halts for good.
        reset_dut();
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 0, 0, 0), "ovf_run");
        for (int k = 0; k < DEPTH; k++) begin
            cyc(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "ovf_fetch");
            cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 12'h100 + 12'(k), 12'h020 + 12'(k),
                   0, 1, 12'h100 + 12'(k), 0, 0, 0, 0), "ovf_call");
        end
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "ovf_fetch5");
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 12'h1FF, 12'h050, 0, 0, 12'h0, 0, 0, 0, 0), "ovf_5th_call");
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 1, 1, 0), "ovf_halt");
        cyc(mk(0, 1, 0, 1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 1, 1, 0), "ovf_stuck");

        // Stall: no ack keeps FETCH with mem_req and no strobes.
        reset_dut();
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 0, 0, 0), "stall_run");
        for (int k = 0; k < 5; k++)
            cyc(mk(0, 0, 0, 0, 1, 1, 1, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "stall");

        // Reset on the third stalled cycle returns to IDLE with quiet outputs.
        reset_dut();
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 0, 0, 0), "srst_run");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "srst_stall1");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "srst_stall2");
        cyc(mk(1, 1, 0, 1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 1, 0, 0, 0), "srst_assert");
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 0, 12'h0, 0, 0, 0, 0), "srst_idle");

        // Random traffic against a queue-based reference model.
        reset_dut();
        m_mode = M_IDLE; m_stack.delete(); m_ovf = 0; m_udf = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_run, r_hreq, r_ack, r_jmp, r_cok, r_cal, r_rt;
            logic [11:0] r_tgt, r_pc, e_pre, nxt;
            logic        e_en, e_ld;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_run  = $urandom_range(0, 1) == 1;
            r_hreq = ($urandom_range(0, 7) == 0);
            r_ack  = $urandom_range(0, 1) == 1;
            r_jmp  = ($urandom_range(0, 3) == 0);
            r_cok  = $urandom_range(0, 1) == 1;
            r_cal  = ($urandom_range(0, 3) == 0);
            r_rt   = ($urandom_range(0, 3) == 0);
            r_tgt  = 12'($urandom);
            r_pc   = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom);
            drive(r_rst, r_run, r_hreq, r_ack, r_jmp, r_cok, r_cal, r_rt, r_tgt, r_pc);

            e_en = 0; e_ld = 0; e_pre = 12'h0;
            if (m_mode == M_EXEC && !r_rst) begin
                if (r_rt) begin
                    if (m_stack.size() > 0) begin e_ld = 1; e_pre = m_stack[$]; end
                end else if (r_cal) begin
                    if (m_stack.size() < DEPTH) begin e_ld = 1; e_pre = r_tgt; end
                end else if (r_jmp && r_cok) begin
                    e_ld = 1; e_pre = r_tgt;
                end else begin
                    e_en = 1;
                end
            end
            @(negedge clk);
            check($sformatf("rand%0d", n), e_en, e_ld, e_pre,
                  m_mode == M_FETCH, m_mode == M_HALT, m_ovf, m_udf);
            $display("cycle rand%0d rst=%b run=%b ack=%b j=%b c=%b call=%b ret=%b depth=%0d",
                     n, r_rst, r_run, r_ack, r_jmp, r_cok, r_cal, r_rt, m_stack.size());

            if (r_rst) begin
                m_mode = M_IDLE; m_stack.delete(); m_ovf = 0; m_udf = 0;
            end else if (m_mode == M_IDLE) begin
                if (r_run) m_mode = M_FETCH;
            end else if (m_mode == M_FETCH) begin
                if (r_ack) m_mode = M_EXEC;
            end else if (m_mode == M_EXEC) begin
                if (r_rt && m_stack.size() == 0) begin
                    m_udf = 1; m_mode = M_HALT;
                end else if (!r_rt && r_cal && m_stack.size() == DEPTH) begin
                    m_ovf = 1; m_mode = M_HALT;
                end else begin
                    if (r_rt) void'(m_stack.pop_back());
                    else if (r_cal) begin nxt = r_pc + 12'd1; m_stack.push_back(nxt); end
                    m_mode = r_hreq ? M_HALT : M_FETCH;
                end
            end else begin
                if (r_run && !m_ovf && !m_udf) m_mode = M_FETCH;
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
